operand_sequencer: RTL

//   Upstream/downstream wrapper stage for the combinational 8-bit adder (Sumador).

---
 rtl/operand_sequencer.sv | 98 +++++++++
 1 files changed

// File: rtl/operand_sequencer.sv
// Operand sequencer around an external combinational adder: loads A then B, captures the sum,
// and presents it downstream. Define OPSEQ_OVF_EN to generate the carry-out flag on out_ovf.
module operand_sequencer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  input  logic [WIDTH-1:0] sum_in,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_ovf,
  output logic [7:0]       res_cnt,
  output logic             busy
);

  typedef enum logic [1:0] {StLoadA, StLoadB, StCalc, StHold} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] op_a_q;
  logic [WIDTH-1:0] op_b_q;
  logic [WIDTH-1:0] out_data_q;
  logic             out_valid_q;
  logic [7:0]       res_cnt_q;

`ifdef OPSEQ_OVF_EN
  logic [WIDTH:0] wide_sum;
  logic           ovf_q;

  // Local carry source; the external adder only exposes the truncated sum.
  assign wide_sum = {1'b0, op_a_q} + {1'b0, op_b_q};
  assign out_ovf  = ovf_q;
`else
  assign out_ovf = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StLoadA;
      op_a_q      <= '0;
      op_b_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      res_cnt_q   <= 8'd0;
`ifdef OPSEQ_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        StLoadA: begin
          if (in_valid) begin
            op_a_q  <= in_data;
            state_q <= StLoadB;
          end
        end
        StLoadB: begin
          if (in_valid) begin
            op_b_q  <= in_data;
            state_q <= StCalc;
          end
        end
        StCalc: begin
          out_data_q  <= sum_in;
          out_valid_q <= 1'b1;
`ifdef OPSEQ_OVF_EN
          ovf_q       <= wide_sum[WIDTH];
`endif
          state_q     <= StHold;
        end
        StHold: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            res_cnt_q   <= res_cnt_q + 8'd1;
`ifdef OPSEQ_OVF_EN
            ovf_q       <= 1'b0;
`endif
            state_q     <= StLoadA;
          end
        end
        default: state_q <= StLoadA;
      endcase
    end
  end

  assign in_ready  = (state_q == StLoadA) || (state_q == StLoadB);
  assign busy      = (state_q != StLoadA);
  assign op_a      = op_a_q;
  assign op_b      = op_b_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign res_cnt   = res_cnt_q;

endmodule
